// File: rtl/bs_job_dispatcher.sv
// bs_job_dispatcher: accepts option-pricing job records, rejects jobs with a
// non-positive strike or expiry, drives a multi-cycle pricer with stable
// operands, and returns one tagged result per accepted job (with timeout).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid=1 keeps its payload stable until that
// edge, and ready never depends combinationally on valid.
module bs_job_dispatcher #(
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_S,
    input  logic signed [15:0] in_K,
    input  logic signed [15:0] in_r,
    input  logic signed [15:0] in_sigma,
    input  logic signed [15:0] in_T,
    input  logic        [7:0]  in_tag,
    output logic               bs_start,
    output logic signed [15:0] bs_S,
    output logic signed [15:0] bs_K,
    output logic signed [15:0] bs_r,
    output logic signed [15:0] bs_sigma,
    output logic signed [15:0] bs_T,
    input  logic               bs_done,
    input  logic signed [15:0] bs_price,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_price,
    output logic        [7:0]  out_tag,
    output logic               out_err,
    output logic        [15:0] jobs_ok,
    output logic        [15:0] jobs_err,
    output logic        [1:0]  dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_bs_start;
    logic                 r_out_valid;
    logic signed [15:0]   r_S;
    logic signed [15:0]   r_K;
    logic signed [15:0]   r_r;
    logic signed [15:0]   r_sigma;
    logic signed [15:0]   r_T;
    logic        [7:0]    r_tag;
    logic signed [15:0]   r_out_price;
    logic                 r_out_err;
    logic        [CW-1:0] r_cnt;
    logic        [15:0]   r_jobs_ok;
    logic        [15:0]   r_jobs_err;

    logic                 w_guard_fail;
    logic        [CW-1:0] w_cnt_next;
    logic                 w_xfer;

    // A job whose strike or expiry is zero or negative is never sent to the pricer.
    assign w_guard_fail = (in_K <= 16'sd0) || (in_T <= 16'sd0);
    assign w_cnt_next   = r_cnt + CW'(1);
    assign w_xfer       = (r_state == EMIT) && out_ready;

    // Job sequencing: accept, issue, wait for the pricer (bounded), emit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_bs_start  <= 1'b0;
            r_out_valid <= 1'b0;
            r_S         <= '0;
            r_K         <= '0;
            r_r         <= '0;
            r_sigma     <= '0;
            r_T         <= '0;
            r_tag       <= '0;
            r_out_price <= '0;
            r_out_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_S        <= in_S;
                        r_K        <= in_K;
                        r_r        <= in_r;
                        r_sigma    <= in_sigma;
                        r_T        <= in_T;
                        r_tag      <= in_tag;
                        r_in_ready <= 1'b0;
                        if (w_guard_fail) begin
                            r_out_price <= '0;
                            r_out_err   <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= EMIT;
                        end else begin
                            r_bs_start <= 1'b1;
                            r_state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_bs_start <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    // A done on the final allowed cycle still counts as success.
                    if (bs_done) begin
                        r_out_price <= bs_price;
                        r_out_err   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= EMIT;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == TIMEOUT_C) begin
                            r_out_price <= '0;
                            r_out_err   <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Completion counters, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_jobs_ok  <= '0;
            r_jobs_err <= '0;
        end else if (w_xfer) begin
            if (r_out_err) begin
                if (r_jobs_err != 16'hFFFF) r_jobs_err <= r_jobs_err + 16'd1;
            end else begin
                if (r_jobs_ok != 16'hFFFF) r_jobs_ok <= r_jobs_ok + 16'd1;
            end
        end
    end

    // Pricer operands come straight from the holding registers, which only
    // change on acceptance, so they are stable through ISSUE and WAIT.
    assign in_ready  = r_in_ready;
    assign bs_start  = r_bs_start;
    assign bs_S      = r_S;
    assign bs_K      = r_K;
    assign bs_r      = r_r;
    assign bs_sigma  = r_sigma;
    assign bs_T      = r_T;
    assign out_valid = r_out_valid;
    assign out_price = r_out_price;
    assign out_tag   = r_tag;
    assign out_err   = r_out_err;
    assign jobs_ok   = r_jobs_ok;
    assign jobs_err  = r_jobs_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bs_job_dispatcher.sv
// Bench for bs_job_dispatcher: directed cases plus randomized jobs, with a
// pricer model and an expected-result queue derived from the dispatcher rules.
module tb_bs_job_dispatcher;

    localparam int TIMEOUT = 15;
    localparam int W = 25; // {err, tag[7:0], price[15:0]}

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_S, in_K, in_r, in_sigma, in_T;
    logic [7:0]  in_tag;
    logic        bs_start;
    logic [15:0] bs_S, bs_K, bs_r, bs_sigma, bs_T;
    logic        bs_done;
    logic [15:0] bs_price;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_price;
    logic [7:0]  out_tag;
    logic        out_err;
    logic [15:0] jobs_ok, jobs_err;
    logic [1:0]  dbg_state;

    bs_job_dispatcher #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_S(in_S), .in_K(in_K), .in_r(in_r), .in_sigma(in_sigma), .in_T(in_T),
        .in_tag(in_tag),
        .bs_start(bs_start),
        .bs_S(bs_S), .bs_K(bs_K), .bs_r(bs_r), .bs_sigma(bs_sigma), .bs_T(bs_T),
        .bs_done(bs_done), .bs_price(bs_price),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_price(out_price), .out_tag(out_tag), .out_err(out_err),
        .jobs_ok(jobs_ok), .jobs_err(jobs_err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_in_ready"}, in_ready, 0);
        check_val({pfx, "_bs_start"}, bs_start, 0);
        check_val({pfx, "_out_valid"}, out_valid, 0);
        check_val({pfx, "_bs_params"}, {bs_S | bs_K | bs_r | bs_sigma | bs_T}, 0);
        check_val({pfx, "_out_price"}, out_price, 0);
        check_val({pfx, "_out_tag"}, out_tag, 0);
        check_val({pfx, "_out_err"}, out_err, 0);
        check_val({pfx, "_jobs_ok"}, jobs_ok, 0);
        check_val({pfx, "_jobs_err"}, jobs_err, 0);
    endtask

    // ---------------- reference model state ----------------
    logic [W-1:0]  exp_q[$];      // expected results in order
    int            exp_cyc_q[$];  // cycle in which out_valid should first rise
    logic [103:0]  pr_q[$];       // {S,K,r,sigma,T,delay[7:0],price} for issued jobs
    int model_ok = 0, model_err = 0;
    int exp_starts = 0, seen_starts = 0;
    int last_xfer_cyc = -100;

    int rdy_mode = 0;   // 0: always ready, 1: random, 2: stall 10 cycles per result
    bit stray_en = 0;   // inject ignored done pulses during ISSUE/EMIT

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the falling edge after acceptance.
    // d = cycles from bs_start to done; 0 = pricer never answers.
    task automatic submit(input logic [15:0] s, k, r, sg, t, input logic [7:0] tag,
                          input int d, input logic [15:0] price, input bit b2b);
        int waited = 0;
        bit guard;
        in_valid = 1'b1;
        in_S = s; in_K = k; in_r = r; in_sigma = sg; in_T = t; in_tag = tag;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            check_val("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        if (b2b) check_val("b2b_accept_cycle", cyc, last_xfer_cyc + 1);
        guard = ($signed(k) <= 0) || ($signed(t) <= 0);
        if (guard) begin
            exp_q.push_back({1'b1, tag, 16'h0000});
            exp_cyc_q.push_back(cyc + 1);
        end else begin
            exp_starts++;
            pr_q.push_back({s, k, r, sg, t, 8'(d), price});
            if (d >= 1 && d <= TIMEOUT) begin
                exp_q.push_back({1'b0, tag, price});
                exp_cyc_q.push_back(cyc + 2 + d);
            end else begin
                exp_q.push_back({1'b1, tag, 16'h0000});
                exp_cyc_q.push_back(cyc + 2 + TIMEOUT);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_S = 16'($urandom); in_K = 16'($urandom); in_r = 16'($urandom);
        in_sigma = 16'($urandom); in_T = 16'($urandom); in_tag = 8'($urandom);
    endtask

    task automatic rand_job(output logic [15:0] s, k, r, sg, t, output logic [7:0] tag,
                            output int d, output logic [15:0] price);
        int sel;
        s = 16'($urandom); r = 16'($urandom); sg = 16'($urandom);
        tag = 8'($urandom); price = 16'($urandom);
        sel = $urandom_range(0, 7);
        k = (sel == 0) ? 16'h0000 : (sel == 1) ? (16'h8000 | 16'($urandom))
                                               : {1'b0, 15'($urandom_range(1, 32767))};
        sel = $urandom_range(0, 7);
        t = (sel == 0) ? 16'h0000 : (sel == 1) ? (16'h8000 | 16'($urandom))
                                               : {1'b0, 15'($urandom_range(1, 32767))};
        d = $urandom_range(0, TIMEOUT);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete(); exp_cyc_q.delete(); pr_q.delete();
        model_ok = 0; model_err = 0; exp_starts = 0; seen_starts = 0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst_mid");
        rst = 1'b0;
        check_val("in_ready_at_release", in_ready, 0);
        @(negedge clk);
        check_val("in_ready_after_release", in_ready, 1);
    endtask

    bit pr_pend = 0;
    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || pr_pend) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_in_time", n < 400, 1);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- pricer model ----------------
    int           pr_cnt = 0;
    logic [103:0] pr_cur;
    initial begin
        bs_done = 1'b0;
        bs_price = 16'h0000;
        forever begin
            @(negedge clk);
            bs_done = 1'b0;
            bs_price = 16'h0000;
            if (rst) begin
                pr_pend = 0;
                continue;
            end
            if (pr_pend) begin
                check_val("bs_S_stable", bs_S, pr_cur[103:88]);
                check_val("bs_K_stable", bs_K, pr_cur[87:72]);
                check_val("bs_r_stable", bs_r, pr_cur[71:56]);
                check_val("bs_sigma_stable", bs_sigma, pr_cur[55:40]);
                check_val("bs_T_stable", bs_T, pr_cur[39:24]);
                pr_cnt--;
                if (pr_cnt == 0) begin
                    bs_done = 1'b1;
                    bs_price = pr_cur[15:0];
                    pr_pend = 0;
                end
            end
            if (bs_start) begin
                seen_starts++;
                if (pr_q.size() == 0) begin
                    check_val("unexpected_bs_start", 1, 0);
                end else begin
                    pr_cur = pr_q.pop_front();
                    check_val("bs_params_at_start", {bs_S, bs_K, bs_r, bs_sigma, bs_T} == pr_cur[103:24], 1);
                    pr_cnt = int'(pr_cur[23:16]);
                    pr_pend = (pr_cnt != 0);
                    if (stray_en && !bs_done && $urandom_range(0, 1) == 0) begin
                        bs_done = 1'b1;
                        bs_price = 16'($urandom);
                    end
                end
            end else if (stray_en && !pr_pend && !bs_done && out_valid && $urandom_range(0, 3) == 0) begin
                bs_done = 1'b1;
                bs_price = 16'($urandom);
            end
        end
    end

    // ---------------- result consumer ----------------
    int stall_cnt = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (out_valid && stall_cnt < 10) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        out_ready = 1'b1;
                        if (!out_valid) stall_cnt = 0;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- scoreboard / monitor ----------------
    bit          prev_v = 0, prev_r = 0;
    logic [15:0] sv_price;
    logic [7:0]  sv_tag;
    logic        sv_err;
    logic [W-1:0] e;
    initial forever begin
        @(negedge clk);
        #2;
        if (rst) begin
            prev_v = 0;
            continue;
        end
        if (out_valid) begin
            check_val("in_ready_in_emit", in_ready, 0);
            check_val("bs_start_in_emit", bs_start, 0);
            if (!prev_v) begin
                if (exp_q.size() != 0) check_val("out_valid_cycle", cyc, exp_cyc_q[0]);
            end else if (!prev_r) begin
                check_val("stall_price_stable", out_price, sv_price);
                check_val("stall_tag_stable", out_tag, sv_tag);
                check_val("stall_err_stable", out_err, sv_err);
            end
            sv_price = out_price;
            sv_tag = out_tag;
            sv_err = out_err;
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    void'(exp_cyc_q.pop_front());
                    check_val("out_price", out_price, e[15:0]);
                    check_val("out_tag", out_tag, e[23:16]);
                    check_val("out_err", out_err, e[24]);
                    check_val("jobs_ok_count", jobs_ok, model_ok);
                    check_val("jobs_err_count", jobs_err, model_err);
                    if (e[24]) model_err++; else model_ok++;
                end
                last_xfer_cyc = cyc;
            end
        end
        prev_v = out_valid;
        prev_r = out_ready;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] s, k, r, sg, t, p;
        logic [7:0]  tg;
        int          d;
        rst = 1'b1;
        in_valid = 1'b0;
        in_S = '0; in_K = '0; in_r = '0; in_sigma = '0; in_T = '0; in_tag = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst0");
        rst = 1'b0;
        check_val("in_ready_at_release0", in_ready, 0);
        @(negedge clk);
        check_val("in_ready_first_edge", in_ready, 1);

        // nominal job
        submit(16'h0C00, 16'h0800, 16'h0100, 16'h0200, 16'h0400, 8'h11, 6, 16'h0455, 0);
        drain();
        check_val("nominal_jobs_ok", jobs_ok, 1);
        check_val("nominal_jobs_err", jobs_err, 0);

        // guard: zero strike, then negative expiry
        submit(16'h0C00, 16'h0000, 16'h0100, 16'h0200, 16'h0400, 8'h22, 6, 16'h1234, 0);
        drain();
        check_val("guard_jobs_err", jobs_err, 1);
        check_val("guard_no_start", seen_starts, 1);
        submit(16'h0C00, 16'h0800, 16'h0100, 16'h0200, 16'hFC00, 8'h23, 4, 16'h1234, 0);
        drain();

        // timeout with a late done, then a pricer that never answers
        submit(16'h0A00, 16'h0900, 16'h0050, 16'h0300, 16'h0200, 8'h33, TIMEOUT + 3, 16'hBEEF, 0);
        drain();
        repeat (5) @(negedge clk);
        submit(16'h0A00, 16'h0900, 16'h0050, 16'h0300, 16'h0200, 8'h34, 0, 16'h0000, 0);
        drain();

        // done exactly on the last allowed cycle, and on the first
        submit(16'h0B00, 16'h0700, 16'h0060, 16'h0180, 16'h0300, 8'h44, TIMEOUT, 16'h0777, 0);
        drain();
        submit(16'h0B00, 16'h0700, 16'h0060, 16'h0180, 16'h0300, 8'h45, 1, 16'h0123, 0);
        drain();

        // backpressure on a priced result and on a rejected one
        rdy_mode = 2;
        submit(16'h0C00, 16'h0800, 16'h0100, 16'h0200, 16'h0400, 8'h55, 3, 16'h0ABC, 0);
        drain();
        submit(16'h0C00, 16'hFF00, 16'h0100, 16'h0200, 16'h0400, 8'h56, 3, 16'h0ABC, 0);
        drain();
        rdy_mode = 0;

        // randomized traffic
        rdy_mode = 1;
        stray_en = 1;
        repeat (40) begin
            rand_job(s, k, r, sg, t, tg, d, p);
            submit(s, k, r, sg, t, tg, d, p, 0);
        end
        drain();
        stray_en = 0;
        rdy_mode = 0;
        check_val("random_jobs_ok", jobs_ok, model_ok);
        check_val("random_jobs_err", jobs_err, model_err);
        check_val("random_starts", seen_starts, exp_starts);

        // reset while waiting on the pricer, and while a result is stalled
        submit(16'h0C00, 16'h0800, 16'h0100, 16'h0200, 16'h0400, 8'h66, 0, 16'h0000, 0);
        repeat (4) @(negedge clk);
        #1;
        do_reset();
        rdy_mode = 2;
        submit(16'h0C00, 16'h0000, 16'h0100, 16'h0200, 16'h0400, 8'h67, 0, 16'h0000, 0);
        repeat (3) @(negedge clk);
        #1;
        do_reset();
        rdy_mode = 0;

        // three back-to-back jobs after the aborted ones
        submit(16'h1000, 16'h0800, 16'h0100, 16'h0200, 16'h0400, 8'h71, 2, 16'h0301, 0);
        submit(16'h1100, 16'h0900, 16'h0110, 16'h0210, 16'h0410, 8'h72, 5, 16'h0302, 1);
        submit(16'h1200, 16'h0A00, 16'h0120, 16'h0220, 16'h0420, 8'h73, 1, 16'h0303, 1);
        drain();
        check_val("final_jobs_ok", jobs_ok, 3);
        check_val("final_jobs_err", jobs_err, 0);
        check_val("final_starts", seen_starts, exp_starts);
        check_val("final_pending", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
